// File: rtl/debug_cmd_sync_decoder_if.sv
// Bundle between the TCK-side debug logic and the clk-side debug core.
// master drives strobes/data/handshake inputs; slave is the decoder.
interface debug_cmd_sync_decoder_if #(
    parameter int unsigned IR_W  = 2,
    parameter int unsigned SR_W  = 38,
    parameter int unsigned OVF_W = 8
);
    localparam int unsigned NUM_CMD = 2 ** IR_W;

    logic                vs_uir;
    logic                vs_udr;
    logic [IR_W-1:0]     ir_in;
    logic [SR_W-1:0]     sr;
    logic                cmd_ready;
    logic                clr_ovf;
    logic                cmd_valid;
    logic [IR_W-1:0]     cmd_ir;
    logic [SR_W-1:0]     jdo;
    logic [NUM_CMD-1:0]  take_action;
    logic [NUM_CMD-1:0]  take_no_action;
    logic                ovf_flag;
    logic [OVF_W-1:0]    ovf_cnt;

    modport master (
        output vs_uir, vs_udr, ir_in, sr, cmd_ready, clr_ovf,
        input  cmd_valid, cmd_ir, jdo, take_action, take_no_action, ovf_flag, ovf_cnt
    );

    modport slave (
        input  vs_uir, vs_udr, ir_in, sr, cmd_ready, clr_ovf,
        output cmd_valid, cmd_ir, jdo, take_action, take_no_action, ovf_flag, ovf_cnt
    );
endinterface

// File: rtl/debug_cmd_sync_decoder.sv
// Synchronises the TCK-domain update-IR/update-DR strobes into clk, captures
// the debug command on update-DR and presents it to the debug core with a
// valid/ready handshake. Commands arriving while one is still pending are
// dropped and counted.
module debug_cmd_sync_decoder #(
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SR_W        = 38,
    parameter int unsigned ACT_BIT     = SR_W - 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OVF_W       = 8
) (
    input logic                      clk,
    input logic                      reset,
    debug_cmd_sync_decoder_if.slave  bus
);
    localparam int unsigned NUM_CMD = 2 ** IR_W;

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic                   uir_hist_q;
    logic                   udr_hist_q;
    logic                   uir_p;
    logic                   udr_p;

    state_e                 state_q, state_d;
    logic [IR_W-1:0]        ir_reg_q, ir_reg_d;
    logic [SR_W-1:0]        jdo_q, jdo_d;
    logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
    logic                   act_q, act_d;
    logic                   ovf_flag_q, ovf_flag_d;
    logic [OVF_W-1:0]       ovf_cnt_q, ovf_cnt_d;
    logic                   drop;
    logic                   cmd_valid;
    logic [NUM_CMD-1:0]     onehot;

    // Strobe synchronisers plus one flop of history for the edge detectors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_hist_q <= 1'b0;
            udr_hist_q <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], bus.vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], bus.vs_udr};
            uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
            udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
        end
    end

    assign uir_p = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
    assign udr_p = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;

    // Command state, captured instruction/data and overrun bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ir_reg_q   <= '0;
            jdo_q      <= '0;
            cmd_ir_q   <= '0;
            act_q      <= 1'b0;
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ir_reg_q   <= ir_reg_d;
            jdo_q      <= jdo_d;
            cmd_ir_q   <= cmd_ir_d;
            act_q      <= act_d;
            ovf_flag_q <= ovf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Next-state: load on udr_p unless a command is pending and not being accepted.
    always_comb begin
        state_d    = state_q;
        jdo_d      = jdo_q;
        cmd_ir_d   = cmd_ir_q;
        act_d      = act_q;
        ovf_flag_d = ovf_flag_q;
        ovf_cnt_d  = ovf_cnt_q;
        drop       = 1'b0;
        // A load in the same cycle as uir_p uses the old ir_reg.
        ir_reg_d   = uir_p ? bus.ir_in : ir_reg_q;

        unique case (state_q)
            StIdle: begin
                if (udr_p) begin
                    state_d  = StPend;
                    jdo_d    = bus.sr;
                    cmd_ir_d = ir_reg_q;
                    act_d    = bus.sr[ACT_BIT];
                end
            end
            StPend: begin
                if (udr_p) begin
                    if (bus.cmd_ready) begin
                        jdo_d    = bus.sr;
                        cmd_ir_d = ir_reg_q;
                        act_d    = bus.sr[ACT_BIT];
                    end else begin
                        drop = 1'b1;
                    end
                end else if (bus.cmd_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear beats the count, but a coincident drop still leaves the flag set.
        if (bus.clr_ovf) begin
            ovf_cnt_d = '0;
        end else if (drop && (ovf_cnt_q != {OVF_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
        end
        if (drop) begin
            ovf_flag_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_flag_d = 1'b0;
        end
    end

    assign cmd_valid = (state_q == StPend);

    // Outputs decoded purely from registers.
    always_comb begin
        onehot             = '0;
        onehot[cmd_ir_q]   = 1'b1;
        bus.take_action    = (cmd_valid && act_q)  ? onehot : '0;
        bus.take_no_action = (cmd_valid && !act_q) ? onehot : '0;
    end

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_ir    = cmd_ir_q;
    assign bus.jdo       = jdo_q;
    assign bus.ovf_flag  = ovf_flag_q;
    assign bus.ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_debug_cmd_sync_decoder.sv
// Scoreboard bench for debug_cmd_sync_decoder: a command-level model predicts
// loads/drops, a negedge monitor pops and compares whenever a command appears.
module tb_debug_cmd_sync_decoder;
    localparam int unsigned IR_W        = 2;
    localparam int unsigned SR_W        = 38;
    localparam int unsigned ACT_BIT     = SR_W - 3;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned OVF_W       = 8;
    localparam int unsigned NUM_CMD     = 2 ** IR_W;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    debug_cmd_sync_decoder_if #(.IR_W(IR_W), .SR_W(SR_W), .OVF_W(OVF_W)) bus ();

    debug_cmd_sync_decoder #(
        .IR_W(IR_W), .SR_W(SR_W), .ACT_BIT(ACT_BIT),
        .SYNC_STAGES(SYNC_STAGES), .OVF_W(OVF_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_loads  = 0;
    logic rnd_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model (command level) ----------------
    int               cyc = 0;
    int               udr_due[$];
    int               uir_due[$];
    cmd_t             exp_q[$];
    logic             m_pend = 1'b0;
    logic [IR_W-1:0]  m_ir = '0;
    logic [OVF_W-1:0] m_cnt = '0;
    logic             m_flag = 1'b0;
    logic             m_prev_udr = 1'b0;
    logic             m_prev_uir = 1'b0;
    logic             m_udr_now, m_uir_now, m_drop;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_pend = 1'b0; m_ir = '0; m_cnt = '0; m_flag = 1'b0;
                m_prev_udr = 1'b0; m_prev_uir = 1'b0;
                udr_due.delete(); uir_due.delete(); exp_q.delete();
            end else begin
                m_udr_now = 1'b0;
                m_uir_now = 1'b0;
                m_drop    = 1'b0;
                if (udr_due.size() > 0 && udr_due[0] == cyc) begin
                    m_udr_now = 1'b1;
                    void'(udr_due.pop_front());
                end
                if (uir_due.size() > 0 && uir_due[0] == cyc) begin
                    m_uir_now = 1'b1;
                    void'(uir_due.pop_front());
                end
                if (m_udr_now) begin
                    if (!m_pend || bus.cmd_ready) begin
                        exp_q.push_back({m_ir, bus.sr});
                        m_pend = 1'b1;
                    end else begin
                        m_drop = 1'b1;
                    end
                end else if (m_pend && bus.cmd_ready) begin
                    m_pend = 1'b0;
                end
                if (bus.clr_ovf) m_cnt = '0;
                else if (m_drop && m_cnt != {OVF_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                if (m_drop) m_flag = 1'b1;
                else if (bus.clr_ovf) m_flag = 1'b0;
                if (m_uir_now) m_ir = bus.ir_in;
                // First sampling edge of a strobe; the effect lands SYNC_STAGES edges later.
                if (bus.vs_udr && !m_prev_udr) udr_due.push_back(cyc + SYNC_STAGES);
                if (bus.vs_uir && !m_prev_uir) uir_due.push_back(cyc + SYNC_STAGES);
                m_prev_udr = bus.vs_udr;
                m_prev_uir = bus.vs_uir;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic             prev_v = 1'b0;
    logic             prev_r = 1'b0;
    cmd_t             cur = '0;
    logic [NUM_CMD-1:0] oh;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else begin
                chk("cmd_valid", 64'(bus.cmd_valid), 64'(m_pend));
                chk("ovf_flag", 64'(bus.ovf_flag), 64'(m_flag));
                chk("ovf_cnt", 64'(bus.ovf_cnt), 64'(m_cnt));
                if (bus.cmd_valid && (!prev_v || prev_r)) begin
                    n_loads++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cmd", 64'(bus.jdo), 64'(0));
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (bus.cmd_valid) begin
                    oh = '0;
                    oh[cur.ir] = 1'b1;
                    chk("cmd_ir", 64'(bus.cmd_ir), 64'(cur.ir));
                    chk("jdo", 64'(bus.jdo), 64'(cur.data));
                    chk("take_action", 64'(bus.take_action), cur.data[ACT_BIT] ? 64'(oh) : 64'(0));
                    chk("take_no_action", 64'(bus.take_no_action),
                        cur.data[ACT_BIT] ? 64'(0) : 64'(oh));
                end else begin
                    chk("take_action_idle", 64'(bus.take_action), 64'(0));
                    chk("take_no_action_idle", 64'(bus.take_no_action), 64'(0));
                end
                prev_v = bus.cmd_valid;
                prev_r = bus.cmd_ready;
            end
        end
    end

    // ---------------- background random handshake ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) begin
                bus.cmd_ready = 1'($urandom_range(0, 1));
                bus.clr_ovf   = ($urandom_range(0, 15) == 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [SR_W-1:0] rand_sr();
        return {6'($urandom), 32'($urandom)};
    endfunction

    task automatic udr_cmd(input logic [SR_W-1:0] d, input int hi, input int lo);
        bus.sr = d;
        bus.vs_udr = 1'b1;
        tick(hi);
        bus.vs_udr = 1'b0;
        tick(lo);
    endtask

    task automatic uir_cmd(input logic [IR_W-1:0] ir, input int hi, input int lo);
        bus.ir_in = ir;
        bus.vs_uir = 1'b1;
        tick(hi);
        bus.vs_uir = 1'b0;
        tick(lo);
    endtask

    logic [SR_W-1:0] d_basic, d_tmp;
    int              loads0;
    int              op;

    initial begin
        bus.vs_uir = 1'b0; bus.vs_udr = 1'b0; bus.ir_in = '0; bus.sr = '0;
        bus.cmd_ready = 1'b0; bus.clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'(0));
        chk("rst_jdo", 64'(bus.jdo), 64'(0));
        chk("rst_cmd_ir", 64'(bus.cmd_ir), 64'(0));
        chk("rst_ovf_cnt", 64'(bus.ovf_cnt), 64'(0));
        reset = 1'b0;
        tick(2);

        // Basic path.
        d_basic = 38'h2A_DEAD_BEEF;
        uir_cmd(2'd2, 1, 3);
        bus.sr = d_basic;
        bus.vs_udr = 1'b1;
        tick(3);
        chk("basic_valid", 64'(bus.cmd_valid), 64'(1));
        chk("basic_ir", 64'(bus.cmd_ir), 64'(2));
        chk("basic_take_action", 64'(bus.take_action), 64'(4'b0100));
        chk("basic_jdo", 64'(bus.jdo), 64'(d_basic));
        bus.vs_udr = 1'b0;
        tick(2);

        // Overrun and saturation.
        udr_cmd(rand_sr(), 1, 3);
        chk("ovr_jdo_hold", 64'(bus.jdo), 64'(d_basic));
        chk("ovr_flag", 64'(bus.ovf_flag), 64'(1));
        chk("ovr_cnt1", 64'(bus.ovf_cnt), 64'(1));
        repeat (300) udr_cmd(rand_sr(), 1, 2);
        chk("ovr_cnt_sat", 64'(bus.ovf_cnt), 64'(255));
        chk("ovr_jdo_hold2", 64'(bus.jdo), 64'(d_basic));
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        chk("clr_flag", 64'(bus.ovf_flag), 64'(0));
        chk("clr_cnt", 64'(bus.ovf_cnt), 64'(0));

        // Drop coinciding with clear.
        bus.sr = rand_sr();
        bus.vs_udr = 1'b1;
        tick(2);
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        bus.vs_udr = 1'b0;
        chk("clrdrop_flag", 64'(bus.ovf_flag), 64'(1));
        chk("clrdrop_cnt", 64'(bus.ovf_cnt), 64'(0));
        tick(2);

        // Accept and load in the same cycle.
        d_tmp = rand_sr();
        bus.sr = d_tmp;
        bus.vs_udr = 1'b1;
        tick(2);
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        bus.vs_udr = 1'b0;
        chk("simul_valid", 64'(bus.cmd_valid), 64'(1));
        chk("simul_jdo", 64'(bus.jdo), 64'(d_tmp));
        chk("simul_cnt", 64'(bus.ovf_cnt), 64'(0));
        tick(2);

        // No-action decode then accept back to idle.
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        chk("accept_idle", 64'(bus.cmd_valid), 64'(0));
        uir_cmd(2'd1, 1, 3);
        d_tmp = rand_sr();
        d_tmp[ACT_BIT] = 1'b0;
        bus.sr = d_tmp;
        bus.vs_udr = 1'b1;
        tick(3);
        bus.vs_udr = 1'b0;
        chk("noact_take_no_action", 64'(bus.take_no_action), 64'(4'b0010));
        chk("noact_take_action", 64'(bus.take_action), 64'(0));
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        chk("noact_idle_tna", 64'(bus.take_no_action), 64'(0));
        chk("noact_idle_valid", 64'(bus.cmd_valid), 64'(0));
        tick(2);

        // Reset while pending, strobe held through release.
        udr_cmd(rand_sr(), 1, 3);
        udr_cmd(rand_sr(), 1, 3);
        chk("prerst_cnt", 64'(bus.ovf_cnt), 64'(1));
        d_tmp = rand_sr();
        bus.sr = d_tmp;
        bus.vs_udr = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.cmd_valid), 64'(0));
        chk("async_rst_jdo", 64'(bus.jdo), 64'(0));
        chk("async_rst_ta", 64'(bus.take_action | bus.take_no_action), 64'(0));
        chk("async_rst_ovf", 64'({bus.ovf_flag, bus.ovf_cnt}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        loads0 = n_loads;
        tick(10);
        bus.vs_udr = 1'b0;
        tick(3);
        chk("rst_strobe_one_load", 64'(n_loads - loads0), 64'(1));
        chk("rst_strobe_jdo", 64'(bus.jdo), 64'(d_tmp));

        // Long strobe gives one load.
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        loads0 = n_loads;
        udr_cmd(rand_sr(), 50, 5);
        chk("long_strobe_one_load", 64'(n_loads - loads0), 64'(1));

        // Randomised traffic.
        rnd_en = 1'b1;
        repeat (200) begin
            op = $urandom_range(0, 2);
            if (op != 1) begin
                bus.ir_in = IR_W'($urandom);
                bus.vs_uir = 1'b1;
            end
            if (op != 0) begin
                bus.sr = rand_sr();
                bus.vs_udr = 1'b1;
            end
            tick($urandom_range(1, 4));
            bus.vs_uir = 1'b0;
            bus.vs_udr = 1'b0;
            tick($urandom_range(2, 5));
        end
        rnd_en = 1'b0;
        tick(1);
        bus.cmd_ready = 1'b1;
        bus.clr_ovf = 1'b0;
        tick(6);
        bus.cmd_ready = 1'b0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk("final_idle", 64'(bus.cmd_valid), 64'(0));
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
